router_reg: RTL

Byte-level datapath register stage of the 1x3 router, directly downstream of the router control FSM. It consumes the FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg) and drives the byte presented to the destination FIFOs. It holds the header byte, buffers one byte across a FIFO-full stall, and computes running packet parity. It returns parity_done and low_pkt_valid to the FSM and raises err on a parity mismatch.

---
 rtl/router_reg.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/router_reg.sv
// router_reg: byte datapath stage between the router FSM and the destination FIFOs.
// Latency: every output is registered; a byte sampled on a clock edge appears on dout after that edge.
// Backpressure: when fifo_full is high in LOAD_DATA, the incoming byte is captured in a one-byte hold buffer and replayed in LOAD_AFTER_FULL.
//
// Ports:
//   clock, resetn       rising-edge clock, synchronous active-low reset
//   pkt_valid, data_in  source byte stream (header byte carries address in [1:0])
//   fifo_full           selected destination FIFO is full
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                       one-hot state strobes from the router FSM
//   dout                byte presented to the destination FIFOs
//   parity_done         parity byte of the current packet has been consumed
//   low_pkt_valid       packet tail (pkt_valid low in LOAD_DATA) has been seen
//   err                 computed parity differs from the received parity byte
module router_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_add,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err
);

    logic [DATA_WIDTH-1:0] r_header_byte;
    logic [DATA_WIDTH-1:0] r_hold_byte;
    logic [DATA_WIDTH-1:0] r_internal_parity;
    logic [DATA_WIDTH-1:0] r_packet_parity;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_parity_done;
    logic                  r_low_pkt_valid;
    logic                  r_err;

    logic w_hdr_load;
    logic w_tail_seen;
    logic w_parity_set;

    // Address 3 does not exist on a 1x3 router, so such a header is never latched.
    assign w_hdr_load   = detect_add && pkt_valid && (data_in[1:0] != 2'b11);
    // The parity byte is the one presented with pkt_valid low while loading data.
    assign w_tail_seen  = ld_state && !pkt_valid;
    // Parity is complete either when the parity byte goes straight through, or
    // when it was stalled in the hold buffer and is replayed after the full state.
    assign w_parity_set = (ld_state && !fifo_full && !pkt_valid)
                       || (laf_state && r_low_pkt_valid && !r_parity_done);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_header_byte <= '0;
        end else if (w_hdr_load) begin
            r_header_byte <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_hold_byte <= '0;
        end else if (ld_state && fifo_full) begin
            r_hold_byte <= data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_dout <= '0;
        end else if (lfd_state) begin
            r_dout <= r_header_byte;
        end else if (ld_state && !fifo_full) begin
            r_dout <= data_in;
        end else if (laf_state) begin
            r_dout <= r_hold_byte;
        end
    end

    // Payload bytes are accumulated when first sampled, stalled or not, so the
    // replay from the hold buffer must not be counted a second time.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_internal_parity <= '0;
        end else if (detect_add) begin
            r_internal_parity <= '0;
        end else if (lfd_state) begin
            r_internal_parity <= r_internal_parity ^ r_header_byte;
        end else if (ld_state && pkt_valid && !full_state) begin
            r_internal_parity <= r_internal_parity ^ data_in;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_packet_parity <= '0;
        end else if (detect_add) begin
            r_packet_parity <= '0;
        end else if (w_tail_seen) begin
            r_packet_parity <= data_in;
        end
    end

    // The tail set takes priority over the clear; the FSM never asserts both.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_low_pkt_valid <= 1'b0;
        end else if (w_tail_seen) begin
            r_low_pkt_valid <= 1'b1;
        end else if (rst_int_reg) begin
            r_low_pkt_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_parity_done <= 1'b0;
        end else if (detect_add) begin
            r_parity_done <= 1'b0;
        end else if (w_parity_set) begin
            r_parity_done <= 1'b1;
        end
    end

    // Compared one cycle after parity_done so both parity registers are final.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_err <= 1'b0;
        end else if (detect_add) begin
            r_err <= 1'b0;
        end else if (r_parity_done) begin
            r_err <= (r_internal_parity != r_packet_parity);
        end
    end

    assign dout          = r_dout;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;

endmodule
